// File: rtl/intersection_controller.sv
// Two-way intersection sequencer: NS/EW traffic-light heads with demand-driven green,
// fixed yellow and all-red clearance, and a latched pedestrian WALK phase.
module intersection_controller #(
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 2,
  parameter int WALK_TICKS   = 6
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ns_sensor,
  input  logic       ew_sensor,
  input  logic       ped_request,
  output logic [1:0] ns_light,
  output logic [1:0] ew_light,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED    = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    WALK      = 3'd5
  } state_t;

  localparam logic [1:0] LIGHT_RED    = 2'b01;
  localparam logic [1:0] LIGHT_YELLOW = 2'b11;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;

  localparam int MAX_AB    = (GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS;
  localparam int MAX_CD    = (ALLRED_TICKS > WALK_TICKS) ? ALLRED_TICKS : WALK_TICKS;
  localparam int MAX_TICKS = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int TW        = $clog2(MAX_TICKS + 1);

  localparam logic [TW-1:0] GREEN_LOAD  = TW'(GREEN_TICKS - 1);
  localparam logic [TW-1:0] YELLOW_LOAD = TW'(YELLOW_TICKS - 1);
  localparam logic [TW-1:0] ALLRED_LOAD = TW'(ALLRED_TICKS - 1);
  localparam logic [TW-1:0] WALK_LOAD   = TW'(WALK_TICKS - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          next_dir_q, next_dir_d;  // 0: NS green next, 1: EW green next
  logic          ped_q, ped_d;
  logic          timer_done;

  assign timer_done = (timer_q == '0);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= NS_GREEN;
      timer_q    <= GREEN_LOAD;
      next_dir_q <= 1'b1;
      ped_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      next_dir_q <= next_dir_d;
      ped_q      <= ped_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_done ? '0 : timer_q - TW'(1);
    next_dir_d = next_dir_q;
    ped_d      = ped_q | ped_request;

    case (state_q)
      NS_GREEN: begin
        if (timer_done && (ew_sensor || ped_q)) begin
          state_d = NS_YELLOW;
          timer_d = YELLOW_LOAD;
        end
      end
      NS_YELLOW: begin
        if (timer_done) begin
          state_d    = ALLRED;
          timer_d    = ALLRED_LOAD;
          next_dir_d = 1'b1;
        end
      end
      EW_GREEN: begin
        if (timer_done && (ns_sensor || ped_q)) begin
          state_d = EW_YELLOW;
          timer_d = YELLOW_LOAD;
        end
      end
      EW_YELLOW: begin
        if (timer_done) begin
          state_d    = ALLRED;
          timer_d    = ALLRED_LOAD;
          next_dir_d = 1'b0;
        end
      end
      ALLRED: begin
        if (timer_done) begin
          if (ped_q) begin
            // Clearing here wins over a same-edge request: that request is served by this walk.
            state_d = WALK;
            timer_d = WALK_LOAD;
            ped_d   = 1'b0;
          end else begin
            state_d = next_dir_q ? EW_GREEN : NS_GREEN;
            timer_d = GREEN_LOAD;
          end
        end
      end
      WALK: begin
        if (timer_done) begin
          state_d = next_dir_q ? EW_GREEN : NS_GREEN;
          timer_d = GREEN_LOAD;
        end
      end
      default: begin
        state_d = NS_GREEN;
        timer_d = GREEN_LOAD;
      end
    endcase
  end

  always_comb begin
    ns_light = LIGHT_RED;
    ew_light = LIGHT_RED;
    walk     = 1'b0;
    case (state_q)
      NS_GREEN:  ns_light = LIGHT_GREEN;
      NS_YELLOW: ns_light = LIGHT_YELLOW;
      EW_GREEN:  ew_light = LIGHT_GREEN;
      EW_YELLOW: ew_light = LIGHT_YELLOW;
      WALK:      walk     = 1'b1;
      default: ;
    endcase
  end

  assign ped_pending = ped_q;
  assign phase       = state_q;

endmodule
